// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

   typedef logic [31:0] inst_bus_t;
   typedef logic [31:0] addr_bus_t;

   localparam inst_bus_t NOP_INST_DEFAULT = '0;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2
   } if_state_t;

   // Sequential fetch increment; wraps at 2^32.
   function automatic addr_bus_t pc_plus4(input addr_bus_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds pc4/inst/valid; load captures, bubble kills.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter inst_bus_t NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc4_d,
   input  logic [31:0] inst_d,
   output logic [31:0] pc4,
   output logic [31:0] inst,
   output logic        valid
);

   // Load takes priority; a bubble keeps pc4 and only invalidates the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc4   <= '0;
         inst  <= NOP_INST;
         valid <= 1'b0;
      end else if (load) begin
         pc4   <= pc4_d;
         inst  <= inst_d;
         valid <= 1'b1;
      end else if (bubble) begin
         inst  <= NOP_INST;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request handshake, redirect handling.
module if_stage
   import if_stage_pkg::*;
#(
   parameter addr_bus_t RESET_PC = 32'h0000_0000,
   parameter inst_bus_t NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        write_pc_ir,
   input  logic        branch,
   input  logic        jump,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid
);

   if_state_t state, state_d;
   addr_bus_t pc, pc_d;
   logic      redirect_pend, redirect_pend_d;
   addr_bus_t pend_target, pend_target_d;
   inst_bus_t hold_buf, hold_buf_d;

   logic      redirect;
   addr_bus_t target;
   addr_bus_t next_pc;
   logic      ifid_load;
   logic      ifid_bubble;
   inst_bus_t ifid_inst_d;

   assign imem_req  = (state == IF_FETCH);
   assign imem_addr = pc;

   // Redirect resolution: jump wins over branch; a deferred target is used once.
   always_comb begin
      redirect = write_pc_ir & (branch | jump);
      target   = jump ? jump_target : branch_target;
      if (redirect)
         next_pc = target;
      else if (redirect_pend)
         next_pc = pend_target;
      else
         next_pc = pc_plus4(pc);
   end

   // Next-state and IF/ID control for the fetch handshake.
   always_comb begin
      state_d         = state;
      pc_d            = pc;
      redirect_pend_d = redirect_pend;
      pend_target_d   = pend_target;
      hold_buf_d      = hold_buf;
      ifid_load       = 1'b0;
      ifid_bubble     = 1'b0;
      ifid_inst_d     = imem_rdata;
      case (state)
         IF_IDLE: state_d = IF_FETCH;
         IF_FETCH: begin
            if (imem_ack) begin
               if (write_pc_ir) begin
                  ifid_load       = 1'b1;
                  pc_d            = next_pc;
                  redirect_pend_d = 1'b0;
               end else begin
                  hold_buf_d = imem_rdata;
                  state_d    = IF_HOLD;
               end
            end else if (write_pc_ir) begin
               // Outstanding fetch is the delay slot; remember the target for after it.
               ifid_bubble = 1'b1;
               if (redirect) begin
                  redirect_pend_d = 1'b1;
                  pend_target_d   = target;
               end
            end
         end
         IF_HOLD: begin
            if (write_pc_ir) begin
               ifid_load       = 1'b1;
               ifid_inst_d     = hold_buf;
               pc_d            = next_pc;
               redirect_pend_d = 1'b0;
               state_d         = IF_FETCH;
            end
         end
         default: state_d = IF_IDLE;
      endcase
   end

   // Fetch-side state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IF_IDLE;
         pc            <= RESET_PC;
         redirect_pend <= 1'b0;
         pend_target   <= '0;
         hold_buf      <= NOP_INST;
      end else begin
         state         <= state_d;
         pc            <= pc_d;
         redirect_pend <= redirect_pend_d;
         pend_target   <= pend_target_d;
         hold_buf      <= hold_buf_d;
      end
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ifid_load),
      .bubble (ifid_bubble),
      .pc4_d  (pc_plus4(pc)),
      .inst_d (ifid_inst_d),
      .pc4    (if_id_pc4),
      .inst   (if_id_inst),
      .valid  (if_id_valid)
   );

   // ID must hold a bubble while a deferred redirect is pending.
   a_no_double_redirect: assert property (@(posedge clk) disable iff (!rst_n)
      !(redirect && redirect_pend))
      else $error("if_stage: redirect while redirect_pend=1");

endmodule
